iob_ethoc_sim_wrapper: RTL and testbench

IOB_ETHOC_SIM_WRAPPER -- requirements
Module: iob_ethoc_sim_wrapper

---
 rtl/iob_ethoc_sim_wrapper.sv | 186 ++++++++++++++++++
 tb/tb_iob_ethoc_sim_wrapper.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/iob_ethoc_sim_wrapper.sv
// Ethernet MAC register/BD model for simulation.
// It loops TX frames back into RX BDs after a fixed transmit delay.
module iob_ethoc_sim_wrapper #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic              valid,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              ethernet_interrupt
);

  typedef enum logic [1:0] {
    IDLE,
    XMIT,
    DONE
  } state_t;

  logic [31:0] bd [256];
  logic [16:0] moder;
  logic [4:0]  int_source;
  logic [6:0]  int_mask;
  state_t      state;
  logic [5:0]  cnt;
  logic [5:0]  tx_ptr;
  logic [5:0]  rx_ptr;

  logic [11:0] a;
  logic        hi_ok;
  logic        reg_sel;
  logic        bd_sel;
  logic [7:0]  widx;
  logic        rd;
  logic        wr;

  assign a       = address[11:0];
  assign hi_ok   = (address >> 12) == '0;
  assign reg_sel = hi_ok && (a[11:10] == 2'b00);
  assign bd_sel  = hi_ok && (a[11:10] == 2'b01);
  assign widx    = a[9:2];
  assign rd      = valid && (wstrb == '0);
  assign wr      = valid && (wstrb != '0);

  function automatic logic [31:0] merge(
    input logic [31:0] old,
    input logic [31:0] d,
    input logic [3:0]  s
  );
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++)
      if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  logic [7:0]  tx_idx;
  logic [7:0]  rx_idx;
  logic [31:0] tx_w0;
  logic [31:0] rx_w0;
  logic        txen;
  logic        lb;
  logic        rx_ok;
  logic        rx_drop;
  logic        done;
  logic [5:0]  tx_nxt;
  logic [5:0]  rx_nxt;

  assign tx_idx  = {1'b0, tx_ptr, 1'b0};
  assign rx_idx  = {1'b1, rx_ptr, 1'b0};
  assign tx_w0   = bd[tx_idx];
  assign rx_w0   = bd[rx_idx];
  assign txen    = moder[1];
  assign lb      = moder[7] && moder[0];
  assign done    = state == DONE;
  assign rx_ok   = lb && rx_w0[15];
  assign rx_drop = lb && !rx_w0[15];
  assign tx_nxt  = (tx_w0[13] || tx_ptr == 6'd63) ? 6'd0 : tx_ptr + 6'd1;
  assign rx_nxt  = (rx_w0[13] || rx_ptr == 6'd63) ? 6'd0 : rx_ptr + 6'd1;

  // Engine writes come after the bus write so they take priority.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      for (int i = 0; i < 256; i++) bd[i] <= '0;
    end else begin
      if (wr && bd_sel)
        bd[widx] <= merge(bd[widx], wdata, wstrb);
      if (done) begin
        bd[tx_idx] <= {tx_w0[31:16], 1'b0, tx_w0[14:0]};
        if (rx_ok)
          bd[rx_idx] <= {tx_w0[31:16], 1'b0, rx_w0[14:0]};
      end
    end
  end

  logic [31:0] moder_w;
  logic [31:0] mask_w;
  logic [4:0]  clr;
  logic [4:0]  set;

  assign moder_w = merge({15'd0, moder}, wdata, wstrb);
  assign mask_w  = merge({25'd0, int_mask}, wdata, wstrb);
  assign clr = (wr && reg_sel && widx == 8'd1 && wstrb[0]) ?
               wdata[4:0] : 5'd0;
  assign set = {done && rx_drop, 1'b0,
                done && rx_ok && rx_w0[14], 1'b0,
                done && tx_w0[14]};

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      moder      <= 17'h0A000;
      int_source <= '0;
      int_mask   <= '0;
    end else begin
      if (wr && reg_sel && widx == 8'd0) moder <= moder_w[16:0];
      if (wr && reg_sel && widx == 8'd2) int_mask <= mask_w[6:0];
      int_source <= (int_source & ~clr) | set;
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state  <= IDLE;
      cnt    <= '0;
      tx_ptr <= '0;
      rx_ptr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (txen && tx_w0[15]) begin
            state <= XMIT;
            cnt   <= '0;
          end
        end
        XMIT: begin
          if (!txen) state <= IDLE;
          else if (cnt == 6'd63) state <= DONE;
          else cnt <= cnt + 6'd1;
        end
        DONE: begin
          state  <= IDLE;
          tx_ptr <= tx_nxt;
          if (rx_ok) rx_ptr <= rx_nxt;
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [31:0] rmux;

  always_comb begin
    rmux = '0;
    if (reg_sel) begin
      case (widx)
        8'd0:    rmux = {15'd0, moder};
        8'd1:    rmux = {27'd0, int_source};
        8'd2:    rmux = {25'd0, int_mask};
        8'd8:    rmux = 32'h40;
        default: rmux = '0;
      endcase
    end else if (bd_sel) begin
      rmux = bd[widx];
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      ready <= 1'b0;
      rdata <= '0;
    end else begin
      ready <= valid;
      rdata <= rd ? rmux : '0;
    end
  end

  assign ethernet_interrupt = |(int_source & int_mask[4:0]);

  logic unused_bits;
  assign unused_bits = ^{a[1:0], int_mask[6:5], rx_w0[31:16]};

endmodule

// File: tb/tb_iob_ethoc_sim_wrapper.sv
// Directed bench for iob_ethoc_sim_wrapper.
// Register access, byte strobes, loopback, drop, abort, reset.
module tb_iob_ethoc_sim_wrapper;

  logic        clk_i = 1'b0;
  logic        arst_n_i = 1'b0;
  logic        valid = 1'b0;
  logic [11:0] address = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic [31:0] rdata;
  logic        ready;
  logic        ethernet_interrupt;

  int n_chk = 0;
  int n_fail = 0;

  iob_ethoc_sim_wrapper #(.ADDR_W(12), .DATA_W(32)) dut (
    .clk_i(clk_i),
    .arst_n_i(arst_n_i),
    .valid(valid),
    .address(address),
    .wdata(wdata),
    .wstrb(wstrb),
    .rdata(rdata),
    .ready(ready),
    .ethernet_interrupt(ethernet_interrupt)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic bus_wr(input logic [11:0] a, input logic [31:0] d,
                        input logic [3:0] s = 4'hF);
    @(negedge clk_i);
    valid = 1'b1; address = a; wdata = d; wstrb = s;
    @(negedge clk_i);
    check("wr_ready", {31'd0, ready}, 32'd1);
    valid = 1'b0; wstrb = '0; wdata = '0;
  endtask

  task automatic rd_chk(input string tag, input logic [11:0] a,
                        input logic [31:0] exp);
    @(negedge clk_i);
    valid = 1'b1; address = a; wstrb = '0;
    @(negedge clk_i);
    check({tag, "_rdy"}, {31'd0, ready}, 32'd1);
    check(tag, rdata, exp);
    valid = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk_i);
    valid = 1'b1;
    @(negedge clk_i);
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_irq", {31'd0, ethernet_interrupt}, 32'd0);
    valid = 1'b0;
    @(negedge clk_i);
    arst_n_i = 1'b1;

    // First access: latency and single-cycle ready
    @(negedge clk_i);
    valid = 1'b1; address = 12'h000;
    @(negedge clk_i);
    check("lat_ready", {31'd0, ready}, 32'd1);
    check("moder_rst", rdata, 32'h0000A000);
    valid = 1'b0;
    @(negedge clk_i);
    check("ready_pulse", {31'd0, ready}, 32'd0);
    check("rdata_idle", rdata, 32'd0);
    check("irq_init", {31'd0, ethernet_interrupt}, 32'd0);
    rd_chk("txbdnum", 12'h020, 32'h40);
    rd_chk("intsrc_rst", 12'h004, 32'h0);
    rd_chk("unmapped", 12'h010, 32'h0);

    bus_wr(12'h000, 32'h0000A080);
    bus_wr(12'h000, 32'h0000A480);
    rd_chk("moder_wr", 12'h000, 32'h0000A480);
    bus_wr(12'h020, 32'h12345678);
    rd_chk("txbdnum_ro", 12'h020, 32'h40);

    bus_wr(12'h604, 32'h00000080);
    bus_wr(12'h600, 32'h0010C000);
    rd_chk("rxbd_w1", 12'h604, 32'h00000080);
    rd_chk("rxbd_w0", 12'h600, 32'h0010C000);
    bus_wr(12'h000, 32'hFFFFFFFF, 4'h1);
    rd_chk("moder_strb", 12'h000, 32'h0000A4FF);

    // Loopback into an empty RX BD
    bus_wr(12'h404, 32'h0);
    bus_wr(12'h400, 32'h0010D000);
    bus_wr(12'h000, 32'h0000A481);
    bus_wr(12'h000, 32'h0000A483);
    repeat (70) @(negedge clk_i);
    rd_chk("lb_txbd", 12'h400, 32'h00105000);
    rd_chk("lb_rxbd", 12'h600, 32'h00104000);
    rd_chk("lb_rxptr", 12'h604, 32'h00000080);
    rd_chk("lb_int", 12'h004, 32'h5);
    check("irq_masked", {31'd0, ethernet_interrupt}, 32'd0);

    bus_wr(12'h008, 32'h7F);
    check("irq_on", {31'd0, ethernet_interrupt}, 32'd1);
    rd_chk("mask_rd", 12'h008, 32'h7F);
    bus_wr(12'h004, 32'h5);
    check("irq_off", {31'd0, ethernet_interrupt}, 32'd0);
    rd_chk("int_clr", 12'h004, 32'h0);

    // Second frame finds RX BD 1 full and is dropped
    bus_wr(12'h608, 32'h00004000);
    bus_wr(12'h408, 32'h0020D000);
    repeat (70) @(negedge clk_i);
    rd_chk("drop_int", 12'h004, 32'h11);
    rd_chk("drop_rxbd", 12'h608, 32'h00004000);
    rd_chk("drop_txbd", 12'h408, 32'h00205000);
    check("irq_busy", {31'd0, ethernet_interrupt}, 32'd1);
    bus_wr(12'h004, 32'h1F);
    rd_chk("int_clr2", 12'h004, 32'h0);

    // Abort by clearing TXEN mid-frame
    arst_n_i = 1'b0;
    @(negedge clk_i);
    arst_n_i = 1'b1;
    bus_wr(12'h400, 32'h0008C000);
    bus_wr(12'h000, 32'h0000A002);
    repeat (10) @(negedge clk_i);
    bus_wr(12'h000, 32'h0000A000);
    repeat (70) @(negedge clk_i);
    rd_chk("abort_bd", 12'h400, 32'h0008C000);
    rd_chk("abort_int", 12'h004, 32'h0);

    // Reset during a frame
    bus_wr(12'h000, 32'h0000A002);
    repeat (20) @(negedge clk_i);
    arst_n_i = 1'b0;
    repeat (2) @(negedge clk_i);
    check("mid_rst_ready", {31'd0, ready}, 32'd0);
    arst_n_i = 1'b1;
    rd_chk("mid_moder", 12'h000, 32'h0000A000);
    rd_chk("mid_bd", 12'h400, 32'h0);
    rd_chk("mid_int", 12'h004, 32'h0);
    rd_chk("mid_mask", 12'h008, 32'h0);
    repeat (70) @(negedge clk_i);
    rd_chk("mid_bd_late", 12'h400, 32'h0);
    check("mid_irq", {31'd0, ethernet_interrupt}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
